// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: queue entry layout,
// FSM state encoding and a PC increment helper.
package fyra_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pcP;
      logic [31:0] pcN;
      logic [31:0] inst;
   } fetch_entry_t;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   function automatic logic [31:0] nextPc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response bus plus the decode-side valid/ready
// channel. master = fetch unit, slave = memory + decode environment.
interface fetch_prefetch_queue_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pcP;
   logic [31:0] out_pcN;
   logic [31:0] out_inst;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_pcP, out_pcN, out_inst,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_pcP, out_pcN, out_inst,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
   );

endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetched instructions. The head entry is
// kept in its own register so the decode outputs never see a read mux from
// storage. Pushes into a full queue never happen (the caller's credit check
// prevents them); pops of an empty queue are ignored.
module fetch_fifo
   import fyra_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fetch_entry_t             pushData,
   input  logic                     pop,
   input  logic                     clear,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  rdPtr, wrPtr, rdPtrNxt;
   logic           doPop;

   assign doPop    = pop & (count != '0);
   assign rdPtrNxt = rdPtr + PW'(1);

   // storage write; contents need no reset, validity is tracked by count
   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[wrPtr] <= pushData;
   end

   // pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push)  wrPtr <= wrPtr + PW'(1);
         if (doPop) rdPtr <= rdPtrNxt;
         count <= count + CW'(push) - CW'(doPop);
      end
   end

   // head register: load the incoming word when the queue is (or becomes) empty,
   // otherwise advance to the next stored entry on a pop
   always_ff @(posedge clk) begin
      if (!rst) begin
         head <= '0;
      end else if (!clear) begin
         if (count == '0 || (doPop && count == CW'(1))) begin
            if (push) head <= pushData;
         end else if (doPop) begin
            head <= mem[rdPtrNxt];
         end
      end
   end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: in-order instruction prefetcher feeding the IF/ID
// register. Requests are credited against queue space so every response
// always has a slot; redirects flush the queue and mark all outstanding
// responses as stale.
// Optional build macro PREFETCH_STATS_EN adds flush/stall statistic counters.
module fetch_prefetch_queue
   import fyra_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en,
   input  logic                  redir_valid,
   input  logic [31:0]           redir_pc,
   fetch_prefetch_queue_if.master bus
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0]           stat_flush_cnt,
   output logic [31:0]           stat_stall_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state, stateNxt;
   logic [31:0]   fpc, rspPc;
   logic [CW-1:0] inflight, dropCnt, qCount;
   logic [CW:0]   committed;
   logic          issueOk, reqValid, reqFire, rspFire, rspPush;
   logic          outValid, outFire;
   fetch_entry_t  head, pushEntry;

   assign committed = {1'b0, inflight} + {1'b0, qCount};

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= BOOT;
      else      state <= stateNxt;
   end

   // next state and issue permission; BOOT lasts exactly one cycle
   always_comb begin
      stateNxt = state;
      issueOk  = 1'b0;
      case (state)
         BOOT: stateNxt = RUN;
         RUN: issueOk = fetch_en & ~redir_valid & (committed < (CW+1)'(DEPTH));
         default: stateNxt = BOOT;
      endcase
   end

   assign reqValid  = rst & issueOk;
   assign reqFire   = reqValid & bus.imem_req_ready;
   assign rspFire   = rst & bus.imem_rsp_valid & (inflight != '0);
   assign rspPush   = rspFire & (dropCnt == '0) & ~redir_valid;
   assign outValid  = rst & (qCount != '0);
   assign outFire   = outValid & bus.out_ready & ~redir_valid;
   assign pushEntry = '{pcP: rspPc, pcN: nextPc(rspPc), inst: bus.imem_rsp_data};

   // fetch/response PCs, outstanding count and stale-response counter.
   // inflight already includes any stale responses still pending, so on a
   // redirect everything still outstanding becomes stale; this keeps
   // back-to-back redirects from double counting.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fpc      <= RESET_PC;
         rspPc    <= RESET_PC;
         inflight <= '0;
         dropCnt  <= '0;
      end else begin
         inflight <= inflight + CW'(reqFire) - CW'(rspFire);
         if (redir_valid) begin
            fpc     <= redir_pc;
            rspPc   <= redir_pc;
            dropCnt <= inflight - CW'(rspFire);
         end else begin
            if (reqFire) fpc <= nextPc(fpc);
            if (rspFire) begin
               if (dropCnt != '0) dropCnt <= dropCnt - CW'(1);
               else               rspPc   <= nextPc(rspPc);
            end
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (rspPush),
      .pushData (pushEntry),
      .pop      (outFire),
      .clear    (redir_valid),
      .count    (qCount),
      .head     (head)
   );

   assign bus.imem_req_valid = reqValid;
   assign bus.imem_req_addr  = (rst && state == RUN) ? fpc : '0;
   assign bus.out_valid      = outValid;
   assign bus.out_pcP        = outValid ? head.pcP  : '0;
   assign bus.out_pcN        = outValid ? head.pcN  : '0;
   assign bus.out_inst       = outValid ? head.inst : '0;

`ifdef PREFETCH_STATS_EN
   logic [31:0] flushCnt, stallCnt;

   // saturating redirect and decode-stall counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         flushCnt <= '0;
         stallCnt <= '0;
      end else begin
         if (redir_valid && flushCnt != '1)               flushCnt <= flushCnt + 32'd1;
         if (outValid && !bus.out_ready && stallCnt != '1) stallCnt <= stallCnt + 32'd1;
      end
   end

   assign stat_flush_cnt = rst ? flushCnt : '0;
   assign stat_stall_cnt = rst ? stallCnt : '0;
`endif

endmodule
